// File: rtl/riscv_mem_pkg.sv
// Shared memory-interface types and limits for the RISC-V memory responders.
// Provides the default address/word width defines if the platform has not already set them.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package riscv_mem_pkg;

    localparam int unsigned MEM_WAIT_MAX = 15;
    localparam int unsigned MEM_CNT_W    = $clog2(MEM_WAIT_MAX + 1);
    localparam int unsigned MEM_BYTES    = `RISCV_WORD_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_rsp_state_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port byte-enabled SRAM with registered read data.
// Array contents are deliberately left unreset; rdata holds until the next read.
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module sram_1rw
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                              clk,
    input  logic                              en,
    input  logic [MEM_BYTES-1:0]              we,
    input  logic [$clog2(DEPTH_WORDS)-1:0]    addr,
    input  logic [`RISCV_WORD_WIDTH-1:0]      wdata,
    output logic [`RISCV_WORD_WIDTH-1:0]      rdata
);

    logic [`RISCV_WORD_WIDTH-1:0] mem [DEPTH_WORDS];

    // Any nonzero byte enable makes this a write; the read port is only updated by reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we == '0) begin
                rdata <= mem[addr];
            end else begin
                for (int unsigned b = 0; b < MEM_BYTES; b++) begin
                    if (we[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one request, inserts WAIT_STATES cycles, pulses ready.
// Define MEM_RESPONDER_RANGE_CHECK_EN to flag/suppress accesses beyond DEPTH_WORDS instead of wrapping.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mem_valid_i,
    output logic                          mem_ready_o,
    input  logic [`RISCV_ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [`RISCV_WORD_WIDTH-1:0]  mem_wdata_i,
    input  logic [3:0]                    mem_we_i,
    output logic [`RISCV_WORD_WIDTH-1:0]  mem_rdata_o,
    output logic                          mem_err_o
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_W = `RISCV_ADDR_WIDTH;
    localparam int unsigned WORD_W = `RISCV_WORD_WIDTH;

    if (!is_pow2(DEPTH_WORDS) || DEPTH_WORDS < 4 || DEPTH_WORDS > 65536) begin : g_bad_depth
        $error("mem_responder: DEPTH_WORDS must be a power of two in 4..65536");
    end
    if (WAIT_STATES > MEM_WAIT_MAX) begin : g_bad_wait
        $error("mem_responder: WAIT_STATES must be in 0..15");
    end

    mem_rsp_state_t        state_q, state_d;
    logic [MEM_CNT_W-1:0]  cnt_q;
    logic [AW-1:0]         idx_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [3:0]            we_q;
    logic                  rd_ok_q;

    logic                  accept;
    logic                  commit;
    logic [AW-1:0]         req_idx;
    logic [WORD_W-1:0]     req_wdata;
    logic [3:0]            req_we;
    logic                  req_oor;
    logic [WORD_W-1:0]     sram_rdata;

    assign accept = (state_q == IDLE) && mem_valid_i;
    assign commit = (state_d == RESP);

    // With zero wait states the commit edge is also the accept edge, so the live inputs
    // feed the array directly while IDLE; otherwise the captured request does.
    always_comb begin
        if (state_q == IDLE) begin
            req_idx   = mem_addr_i[AW+1:2];
            req_wdata = mem_wdata_i;
            req_we    = mem_we_i;
        end else begin
            req_idx   = idx_q;
            req_wdata = wdata_q;
            req_we    = we_q;
        end
    end

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(64'(DEPTH_WORDS) * 64'd4);
    logic oor_q;

    always_comb begin
        req_oor = (state_q == IDLE) ? (mem_addr_i >= ADDR_LIMIT) : oor_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oor_q <= 1'b0;
        end else if (accept) begin
            oor_q <= req_oor;
        end
    end
`else
    logic unused_addr_bits;

    always_comb begin
        req_oor          = 1'b0;
        unused_addr_bits = ^{mem_addr_i[ADDR_W-1:AW+2], mem_addr_i[1:0]};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == MEM_CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= '0;
        end else if (accept) begin
            cnt_q   <= MEM_CNT_W'(WAIT_STATES);
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            we_q    <= req_we;
        end else if (state_q == WAIT) begin
            cnt_q   <= cnt_q - MEM_CNT_W'(1);
        end
    end

    // Masks the SRAM read port until a read completes, and zeroes out-of-range reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok_q <= 1'b0;
        end else if (commit && (req_we == '0)) begin
            rd_ok_q <= !req_oor;
        end
    end

    sram_1rw #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (commit && !req_oor),
        .we    (req_we),
        .addr  (req_idx),
        .wdata (req_wdata),
        .rdata (sram_rdata)
    );

    always_comb begin
        mem_ready_o = (state_q == RESP);
        mem_rdata_o = rd_ok_q ? sram_rdata : '0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        mem_err_o   = (state_q == RESP) && oor_q;
`else
        mem_err_o   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_STATES 0, 2 and 3.
// Range-check expectations follow MEM_RESPONDER_RANGE_CHECK_EN as seen by this file.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module tb_mem_responder;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        rst_n [3];
    logic        valid [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  we    [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int vectors;
    int miscompares;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n[0]), .mem_valid_i(valid[0]), .mem_ready_o(ready[0]),
        .mem_addr_i(addr[0]), .mem_wdata_i(wdata[0]), .mem_we_i(we[0]),
        .mem_rdata_o(rdata[0]), .mem_err_o(err[0])
    );
    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst_n(rst_n[1]), .mem_valid_i(valid[1]), .mem_ready_o(ready[1]),
        .mem_addr_i(addr[1]), .mem_wdata_i(wdata[1]), .mem_we_i(we[1]),
        .mem_rdata_o(rdata[1]), .mem_err_o(err[1])
    );
    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n[2]), .mem_valid_i(valid[2]), .mem_ready_o(ready[2]),
        .mem_addr_i(addr[2]), .mem_wdata_i(wdata[2]), .mem_we_i(we[2]),
        .mem_rdata_o(rdata[2]), .mem_err_o(err[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    // One request with valid held until the ready pulse; ready must appear exactly WS+1 edges later.
    task automatic xact(input int k, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] w, input logic exp_err, output logic [31:0] rd);
        int ws;
        ws       = ws_of(k);
        rd       = '0;
        valid[k] = 1'b1;
        addr[k]  = a;
        wdata[k] = wd;
        we[k]    = w;
        for (int c = 1; c <= ws + 1; c++) begin
            tick();
            if (c <= ws) begin
                check("ready_early", 32'(ready[k]), 32'd0);
            end else begin
                check("ready_pulse", 32'(ready[k]), 32'd1);
                check("err_resp", 32'(err[k]), 32'(exp_err));
                rd       = rdata[k];
                valid[k] = 1'b0;
            end
        end
        tick();
        check("ready_one_cycle", 32'(ready[k]), 32'd0);
        check("err_idle", 32'(err[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            valid[k] = 1'b0;
            addr[k]  = '0;
            wdata[k] = '0;
            we[k]    = '0;
        end
        tick();
        valid[0] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(ready[k]), 32'd0);
            check("rst_rdata", rdata[k], 32'h0);
            check("rst_err", 32'(err[k]), 32'd0);
        end
        valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        tick();

        // Zero wait states: write then read back, low address bits ignored
        xact(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        xact(0, 32'h10, 32'h0, 4'h0, 1'b0, rd);
        check("ws0_read", rd, 32'hDEADBEEF);
        xact(0, 32'h13, 32'h0, 4'h0, 1'b0, rd);
        check("ws0_unaligned", rd, 32'hDEADBEEF);

        // Byte enables; read data must survive intervening writes
        xact(0, 32'h20, 32'h11223344, 4'hF, 1'b0, rd);
        xact(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd);
        check("rdata_hold_wr", rdata[0], 32'hDEADBEEF);
        xact(0, 32'h20, 32'h0, 4'h0, 1'b0, rd);
        check("byte_en", rd, 32'h11BB33DD);

        // Out-of-range access at 4*DEPTH_WORDS
        xact(0, 32'h0, 32'h13579BDF, 4'hF, 1'b0, rd);
        xact(0, 32'h1000, 32'h2468ACE0, 4'hF, RC, rd);
        xact(0, 32'h0, 32'h0, 4'h0, 1'b0, rd);
        check("oor_word0", rd, RC ? 32'h13579BDF : 32'h2468ACE0);
        xact(0, 32'h1000, 32'h0, 4'h0, RC, rd);
        check("oor_read", rd, RC ? 32'h0 : 32'h2468ACE0);

        // WAIT_STATES=3 with valid held: ready in cycles 4 and 9 only
        xact(2, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, rd);
        valid[2] = 1'b1;
        addr[2]  = 32'h40;
        we[2]    = 4'h0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check("ws3_held_ready", 32'(ready[2]), (c == 4 || c == 9) ? 32'd1 : 32'd0);
            if (c == 4) check("ws3_read", rdata[2], 32'hCAFEF00D);
        end
        valid[2] = 1'b0;
        tick();
        check("ws3_after", 32'(ready[2]), 32'd0);

        // WAIT_STATES=2: request inputs scrambled after acceptance
        valid[1] = 1'b1;
        addr[1]  = 32'h8;
        wdata[1] = 32'h55AA55AA;
        we[1]    = 4'hF;
        tick();
        valid[1] = 1'b0;
        addr[1]  = 32'hC;
        wdata[1] = 32'h0;
        we[1]    = 4'h0;
        check("drop_c1", 32'(ready[1]), 32'd0);
        tick();
        check("drop_c2", 32'(ready[1]), 32'd0);
        tick();
        check("drop_c3", 32'(ready[1]), 32'd1);
        tick();
        check("drop_c4", 32'(ready[1]), 32'd0);
        xact(1, 32'h8, 32'h0, 4'h0, 1'b0, rd);
        check("drop_commit", rd, 32'h55AA55AA);

        // Reset during WAIT aborts the write
        xact(1, 32'h4, 32'h01020304, 4'hF, 1'b0, rd);
        xact(1, 32'h4, 32'h0, 4'h0, 1'b0, rd);
        check("abort_pre", rd, 32'h01020304);
        valid[1] = 1'b1;
        addr[1]  = 32'h4;
        wdata[1] = 32'hFFFFFFFF;
        we[1]    = 4'hF;
        tick();
        valid[1] = 1'b0;
        rst_n[1] = 1'b0;
        #1;
        check("abort_rdata", rdata[1], 32'h0);
        check("abort_ready_rst", 32'(ready[1]), 32'd0);
        tick();
        rst_n[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_no_ready", 32'(ready[1]), 32'd0);
        end
        xact(1, 32'h4, 32'h0, 4'h0, 1'b0, rd);
        check("abort_word", rd, 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
